// File: rtl/cpu_types_pkg.sv
// Shared datapath types and the memory-stage state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_llsc_link.sv
// Load-linked / store-conditional link register (valid + address).
// Compiled only when MEM_STAGE_LLSC_EN is defined.
`ifdef MEM_STAGE_LLSC_EN
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  set_link,
    input  word_t set_addr,
    input  logic  store_done,
    input  word_t store_addr,
    output logic  link_valid,
    output word_t link_addr
);

    // A completed ll arms the link; any completed store to the linked word disarms it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= 32'd0;
        end else if (set_link) begin
            link_valid <= 1'b1;
            link_addr  <= set_addr;
        end else if (store_done && link_valid && (store_addr == link_addr)) begin
            link_valid <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/mem_stage.sv
// Pipeline MEM stage: single-outstanding data-cache access FSM with stall.
// Optional LL/SC link support is enabled by defining MEM_STAGE_LLSC_EN.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ex_valid,
    input  word_t    ex_aluOut,
    input  word_t    ex_rdat2,
    input  regbits_t ex_wsel,
    input  logic     ex_regWEN,
    input  logic     ex_MemToReg,
    input  logic     ex_dMemREN,
    input  logic     ex_dMemWEN,
    input  logic     ex_Halt,
    input  word_t    ex_pcplus4,
    input  logic     ex_ll,
    input  logic     ex_sc,
    input  logic     flush,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    input  logic     dhit,
    input  word_t    dmemload,
    output logic     stall,
    output logic     wb_valid,
    output word_t    wb_wdat,
    output regbits_t wb_wsel,
    output logic     wb_regWEN,
    output word_t    wb_pcplus4,
    output logic     wb_halt
);

    mem_state_t state;
    word_t      req_addr, req_data, req_pcplus4;
    regbits_t   req_wsel;
    logic       req_regwen, req_ren, req_wen, req_sc;
    logic       accept_s, is_rd_s, is_wr_s, mem_op_s, sc_pass_s, sc_fail_s;
    logic       unused_s;

    // Write-back source is chosen from the op type, so MemToReg carries no extra information here.
    assign unused_s = ex_MemToReg;
    assign accept_s = (state == IDLE) && ex_valid && !flush;

`ifdef MEM_STAGE_LLSC_EN
    logic  link_valid, req_ll;
    word_t link_addr;

    assign sc_pass_s = ex_sc && link_valid && (link_addr == ex_aluOut);
    assign sc_fail_s = ex_sc && !sc_pass_s;

    llsc_link u_llsc_link (
        .CLK        (CLK),
        .RST        (RST),
        .set_link   ((state == ACCESS) && dhit && req_ren && req_ll),
        .set_addr   (req_addr),
        .store_done ((state == ACCESS) && dhit && req_wen),
        .store_addr (req_addr),
        .link_valid (link_valid),
        .link_addr  (link_addr)
    );
`else
    assign sc_pass_s = 1'b0;
    assign sc_fail_s = 1'b0;
`endif

    // A failed sc turns into a plain ALU-style completion with no memory traffic.
    assign is_rd_s  = ex_dMemREN || ex_ll;
    assign is_wr_s  = !is_rd_s && (ex_dMemWEN || ex_sc) && !sc_fail_s;
    assign mem_op_s = is_rd_s || is_wr_s;

    assign dmemREN   = (state == ACCESS) && req_ren;
    assign dmemWEN   = (state == ACCESS) && req_wen;
    assign dmemaddr  = req_addr;
    assign dmemstore = req_data;

    // Stall is combinational so upstream freezes in the same cycle a memory op is offered.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = accept_s && !ex_Halt && mem_op_s;
            ACCESS:  stall = !dhit;
            HALTED:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // State, request capture and MEM/WB register update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            req_addr    <= 32'd0;
            req_data    <= 32'd0;
            req_pcplus4 <= 32'd0;
            req_wsel    <= 5'd0;
            req_regwen  <= 1'b0;
            req_ren     <= 1'b0;
            req_wen     <= 1'b0;
            req_sc      <= 1'b0;
`ifdef MEM_STAGE_LLSC_EN
            req_ll      <= 1'b0;
`endif
            wb_valid    <= 1'b0;
            wb_wdat     <= 32'd0;
            wb_wsel     <= 5'd0;
            wb_regWEN   <= 1'b0;
            wb_pcplus4  <= 32'd0;
            wb_halt     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!accept_s) begin
                        wb_valid <= 1'b0;
                    end else if (ex_Halt) begin
                        wb_valid   <= 1'b1;
                        wb_wdat    <= ex_aluOut;
                        wb_wsel    <= ex_wsel;
                        wb_regWEN  <= ex_regWEN;
                        wb_pcplus4 <= ex_pcplus4;
                        wb_halt    <= 1'b1;
                        state      <= HALTED;
                    end else if (mem_op_s) begin
                        req_addr    <= ex_aluOut;
                        req_data    <= ex_rdat2;
                        req_pcplus4 <= ex_pcplus4;
                        req_wsel    <= ex_wsel;
                        req_regwen  <= ex_regWEN;
                        req_ren     <= is_rd_s;
                        req_wen     <= is_wr_s;
                        req_sc      <= sc_pass_s;
`ifdef MEM_STAGE_LLSC_EN
                        req_ll      <= ex_ll;
`endif
                        wb_valid    <= 1'b0;
                        state       <= ACCESS;
                    end else begin
                        wb_valid   <= 1'b1;
                        wb_wdat    <= sc_fail_s ? 32'd0 : ex_aluOut;
                        wb_wsel    <= ex_wsel;
                        wb_regWEN  <= ex_regWEN;
                        wb_pcplus4 <= ex_pcplus4;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        wb_valid   <= 1'b1;
                        wb_wdat    <= req_ren ? dmemload : (req_sc ? 32'd1 : req_addr);
                        wb_wsel    <= req_wsel;
                        wb_regWEN  <= req_regwen;
                        wb_pcplus4 <= req_pcplus4;
                        state      <= IDLE;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                HALTED: begin
                    wb_valid <= 1'b0;
                end
                default: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
